// File: rtl/hv_alu_pipe_if.sv
// rtl/hv_alu_pipe_if.sv - operand/result handshake bundle for the hypervector ALU
interface hv_alu_pipe_if #(
  parameter int HVDimension = 512,
  parameter int ShiftWidth  = $clog2(HVDimension)
);
  logic [HVDimension-1:0] a_i;
  logic [HVDimension-1:0] b_i;
  logic [2:0]             op_i;
  logic [ShiftWidth-1:0]  shift_amt_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [HVDimension-1:0] c_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic                   busy_o;

  modport master (
    output a_i, b_i, op_i, shift_amt_i, in_valid_i, out_ready_i,
    input  in_ready_o, c_o, out_valid_o, busy_o
  );

  modport slave (
    input  a_i, b_i, op_i, shift_amt_i, in_valid_i, out_ready_i,
    output in_ready_o, c_o, out_valid_o, busy_o
  );
endinterface

// File: rtl/hv_alu_pipe.sv
// rtl/hv_alu_pipe.sv - element-wise hypervector ALU with iterative circular rotation
module hv_alu_pipe #(
  parameter int HVDimension   = 512,
  parameter int ShiftPerCycle = 16,
  parameter int ShiftWidth    = $clog2(HVDimension),
  parameter int CountWidth    = ShiftWidth - $clog2(ShiftPerCycle) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hv_alu_pipe_if.slave  bus
);

  localparam int LogSpc = $clog2(ShiftPerCycle);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                 state_q, state_d;
  logic [HVDimension-1:0] work_q, work_d;
  logic [HVDimension-1:0] c_q, c_d;
  logic                   out_valid_q, out_valid_d;
  logic [CountWidth-1:0]  count_q, count_d;

  logic                   accept;
  logic                   is_rot;
  logic [ShiftWidth-1:0]  r_eff;
  logic [ShiftWidth-1:0]  residual;
  logic [CountWidth-1:0]  steps;
  logic [HVDimension-1:0] res_rot;
  logic [HVDimension-1:0] work_step;
  logic [HVDimension-1:0] alu_res;

  function automatic logic [HVDimension-1:0] rotr(input logic [HVDimension-1:0] x, input int n);
    logic [2*HVDimension-1:0] w;
    w = {x, x} >> n;
    return w[HVDimension-1:0];
  endfunction

  assign bus.in_ready_o  = (state_q == IDLE) && (!out_valid_q || bus.out_ready_i);
  assign bus.c_o         = c_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.busy_o      = (state_q == SHIFT);

  assign accept   = bus.in_valid_i && bus.in_ready_o;
  assign is_rot   = (bus.op_i == 3'd3) || (bus.op_i == 3'd7);
  // Left rotation is a right rotation by the two's complement amount.
  assign r_eff    = (bus.op_i == 3'd7) ? (ShiftWidth'(0) - bus.shift_amt_i) : bus.shift_amt_i;
  assign residual = r_eff & ShiftWidth'(ShiftPerCycle - 1);
  assign steps    = CountWidth'(r_eff >> LogSpc);
  assign work_step = rotr(work_q, ShiftPerCycle);

  // Small barrel covering only the sub-step residual; the rest is done in SHIFT.
  always_comb begin
    res_rot = bus.a_i;
    for (int s = 0; s < ShiftPerCycle; s++) begin
      if (residual == ShiftWidth'(s)) res_rot = rotr(bus.a_i, s);
    end
  end

  always_comb begin
    alu_res = '0;
    case (bus.op_i)
      3'd0:    alu_res = bus.a_i ^ bus.b_i;
      3'd1:    alu_res = bus.a_i;
      3'd2:    alu_res = bus.b_i;
      3'd4:    alu_res = bus.a_i & bus.b_i;
      3'd5:    alu_res = bus.a_i | bus.b_i;
      3'd6:    alu_res = ~bus.a_i;
      default: alu_res = res_rot;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    c_d         = c_q;
    out_valid_d = out_valid_q && !bus.out_ready_i;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_rot || steps == '0) begin
            c_d         = alu_res;
            out_valid_d = 1'b1;
          end else begin
            work_d  = res_rot;
            count_d = steps;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        work_d  = work_step;
        count_d = count_q - CountWidth'(1);
        if (count_q == CountWidth'(1)) begin
          c_d         = work_step;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      work_q      <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_hv_alu_pipe.sv
// tb/tb_hv_alu_pipe.sv - directed and randomized checks of hv_alu_pipe against a behavioural model
module tb_hv_alu_pipe;
  localparam int D   = 512;
  localparam int SPC = 16;
  localparam int SW  = $clog2(D);
  localparam int NRND = 150;

  typedef logic [D-1:0] hv_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  hv_alu_pipe_if #(.HVDimension(D)) bus ();

  hv_alu_pipe #(.HVDimension(D), .ShiftPerCycle(SPC)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input hv_t obs, input hv_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic hv_t model(input logic [2:0] op, input hv_t a, input hv_t b, input int k);
    hv_t c;
    c = '0;
    case (op)
      3'd0: c = a ^ b;
      3'd1: c = a;
      3'd2: c = b;
      3'd3: for (int i = 0; i < D; i++) c[i] = a[(i + k) % D];
      3'd4: c = a & b;
      3'd5: c = a | b;
      3'd6: c = ~a;
      3'd7: for (int i = 0; i < D; i++) c[i] = a[(i - k + D) % D];
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input int k);
    if (op == 3'd3) return 1 + k / SPC;
    if (op == 3'd7) return 1 + ((D - k) % D) / SPC;
    return 1;
  endfunction

  function automatic hv_t rand_hv();
    hv_t v;
    for (int i = 0; i < D / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_op(input string tag, input logic [2:0] op, input hv_t a, input hv_t b,
                        input int k, input hv_t exp_c, input int exp_lat);
    int lat;
    int busy_n;
    bus.out_ready_i = 1'b1;
    #1;
    check({tag, "_rdy"}, hv_t'(bus.in_ready_o), hv_t'(1));
    bus.op_i        = op;
    bus.a_i         = a;
    bus.b_i         = b;
    bus.shift_amt_i = SW'(k);
    bus.in_valid_i  = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    lat    = 1;
    busy_n = 0;
    while (!bus.out_valid_o && lat < 64) begin
      busy_n += int'(bus.busy_o);
      @(negedge clk);
      lat++;
    end
    check({tag, "_c"}, bus.c_o, exp_c);
    check({tag, "_lat"}, hv_t'(lat), hv_t'(exp_lat));
    check({tag, "_busy"}, hv_t'(busy_n), hv_t'(exp_lat - 1));
  endtask

  initial begin
    hv_t aa, ff, one, held;
    hv_t q[$];
    int  acc, done, cyc, seen;
    bit  pending;
    logic [2:0] rop;
    hv_t ra, rb;
    int  rk;
    int  picks[6];

    n_checks = 0;
    n_errors = 0;
    aa  = {64{8'hAA}};
    ff  = {64{8'hFF}};
    one = hv_t'(1);
    picks[0] = 0; picks[1] = 1; picks[2] = 15;
    picks[3] = 16; picks[4] = 17; picks[5] = 511;

    rst = 1'b1;
    bus.a_i = '0; bus.b_i = '0; bus.op_i = '0; bus.shift_amt_i = '0;
    bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_c", bus.c_o, '0);
    check("rst_ov", hv_t'(bus.out_valid_o), '0);
    check("rst_busy", hv_t'(bus.busy_o), '0);
    check("rst_rdy", hv_t'(bus.in_ready_o), hv_t'(1));

    run_op("xor",  3'd0, aa, ff, 0, {64{8'h55}}, 1);
    run_op("and",  3'd4, aa, ff, 0, {64{8'hAA}}, 1);
    run_op("or",   3'd5, aa, ff, 0, {64{8'hFF}}, 1);
    run_op("nota", 3'd6, aa, ff, 0, {64{8'h55}}, 1);
    run_op("passb", 3'd2, aa, ff, 0, {64{8'hFF}}, 1);
    run_op("passa", 3'd1, aa, ff, 0, aa, 1);

    run_op("rr1",   3'd3, one, '0, 1,   one << 511, 1);
    run_op("rr37",  3'd3, one, '0, 37,  one << 475, 3);
    run_op("rl37",  3'd7, one, '0, 37,  one << 37,  model_lat(3'd7, 37));
    run_op("rl0",   3'd7, one, '0, 0,   one,        1);
    run_op("rr511", 3'd3, one, '0, 511, one << 1,   32);
    run_op("rl1",   3'd7, one, '0, 1,   one << 1,   32);

    // Backpressure: the held result must stay put while the next request waits.
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    bus.op_i = 3'd0; bus.a_i = aa; bus.b_i = ff; bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check("bp_ov", hv_t'(bus.out_valid_o), hv_t'(1));
    check("bp_c", bus.c_o, {64{8'h55}});
    held = bus.c_o;
    bus.op_i = 3'd4; bus.a_i = ff; bus.b_i = aa; bus.in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_stable", bus.c_o, held);
      check("bp_rdy", hv_t'(bus.in_ready_o), '0);
      @(negedge clk);
    end
    bus.out_ready_i = 1'b1;
    #1;
    check("bp_rdy_release", hv_t'(bus.in_ready_o), hv_t'(1));
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check("bp_next_ov", hv_t'(bus.out_valid_o), hv_t'(1));
    check("bp_next_c", bus.c_o, {64{8'hAA}});

    // Reset during the fifth SHIFT cycle drops the in-flight rotation.
    @(negedge clk);
    bus.op_i = 3'd3; bus.a_i = one; bus.shift_amt_i = SW'(511); bus.in_valid_i = 1'b1;
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    check("mr_busy", hv_t'(bus.busy_o), hv_t'(1));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mr_ov", hv_t'(bus.out_valid_o), '0);
    check("mr_busy0", hv_t'(bus.busy_o), '0);
    check("mr_c", bus.c_o, '0);
    rst = 1'b0;
    #1;
    check("mr_rdy", hv_t'(bus.in_ready_o), hv_t'(1));
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid_o) seen++;
    end
    check("mr_spurious", hv_t'(seen), '0);

    // Randomized regression against the model and a result scoreboard.
    acc = 0; done = 0; cyc = 0; pending = 1'b0;
    while ((acc < NRND || q.size() != 0) && cyc < 20000) begin
      if (!pending) begin
        if (acc < NRND) begin
          rop = 3'($urandom_range(0, 7));
          ra  = rand_hv();
          rb  = rand_hv();
          rk  = ($urandom_range(0, 3) == 0) ? picks[$urandom_range(0, 5)] : int'($urandom_range(0, D - 1));
          bus.op_i = rop; bus.a_i = ra; bus.b_i = rb; bus.shift_amt_i = SW'(rk);
          bus.in_valid_i = 1'b1;
          pending = 1'b1;
        end else begin
          bus.in_valid_i = 1'b0;
        end
      end
      bus.out_ready_i = (acc >= NRND) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (q.size() == 0) check("rnd_extra", hv_t'(1), '0);
        else check("rnd_c", bus.c_o, q.pop_front());
        done++;
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        q.push_back(model(rop, ra, rb, rk));
        acc++;
        pending = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    check("rnd_accepted", hv_t'(acc), hv_t'(NRND));
    check("rnd_handshakes", hv_t'(done), hv_t'(acc));
    check("rnd_queue_empty", hv_t'(q.size()), '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
